throughout_and_checker: RTL and testbench
=========================================

Name: throughout_and_checker

Overview:
- Synthesizable RTL monitor for the property "qual throughout (ev[0] and ev[1] and ... ev[N-1])", resolved with first-match semantics.
- It generalises the two-operand bench check to NUM_EV event channels.
- It adds a programmable completion window, a timeout, and failure-cause reporting.
- It also keeps saturating pass and fail counters.
- It sits beside protocol blocks as an on-chip checker and drives status and counter registers.

Parameters:
- NUM_EV, 2: number of event channels ANDed together. Legal range is 2..16.
- MAX_WIN, 15: largest programmable window, in cycles after the start cycle.
- CNT_W, $clog2(MAX_WIN+1): width of the window and latency fields. Derived; do not override.
- STAT_W, 16: width of the saturating pass and fail counters.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: opens an attempt when the checker is IDLE.
- qual, in, 1: qualifier; must be 1 on every sampled cycle of the attempt.
- ev, in, NUM_EV: per-channel event levels, sampled each cycle.
- win_len, in, CNT_W: window length. Sampled only on the cycle the attempt is accepted.
- busy, out, 1: high while in TRACK.
- pass, out, 1: one-cycle pulse when an attempt matches.
- fail, out, 1: one-cycle pulse when an attempt fails.
- fail_cause, out, 2: 0 = none, 1 = QUAL, 2 = TIMEOUT.
- offend_idx, out, $clog2(NUM_EV): lowest channel index still unseen at TIMEOUT; 0 otherwise.
- latency, out, CNT_W: cycles from the start cycle to the match. Valid with pass.
- start_drop, out, 1: pulse when start arrives while busy.
- pass_cnt, out, STAT_W: saturating count of passes.
- fail_cnt, out, STAT_W: saturating count of fails.

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE, seen_mask is 0 and elapsed is 0. Reset is asynchronous and takes effect immediately, including mid-attempt. An attempt in progress is discarded with no pass or fail.
- All outputs are registered. A decision sampled at edge k appears on the outputs after edge k and lasts exactly one cycle.
- FSM states: IDLE and TRACK.
- IDLE, start=1, cycle 0 of the attempt:
  - Latch win_len and clear elapsed.
  - Evaluate the start cycle itself (sampled values on the same edge):
    - qual=0: fail with cause QUAL, remain IDLE.
    - Otherwise, if every ev bit is 1: pass with latency=0, remain IDLE.
    - Otherwise, if win_len=0: fail with cause TIMEOUT.
    - Otherwise: seen_mask = ev, go to TRACK.
- TRACK, each cycle, evaluated in priority order:
  1. qual=0: fail QUAL. This has priority even if the last event arrives on the same cycle, because throughout covers the end point. Go to IDLE.
  2. (seen_mask | ev) is all ones: pass with latency = elapsed+1 (the count including this cycle). Go to IDLE.
  3. elapsed+1 = latched window: fail TIMEOUT, with offend_idx = lowest zero bit of (seen_mask|ev). Go to IDLE.
  4. Otherwise: seen_mask |= ev, elapsed++.
- Event-level rules:
  - Events are level samples. A channel counts once seen, even if it later drops (sticky OR).
  - Channels may complete in any order or all together. The match ends at the latest one, per sequence-and semantics.
- First match: only the earliest completion is reported. Events after a pass are ignored until the next start.
- start while in TRACK: ignored, and start_drop pulses. No overlapping attempts are allowed.
- start on the same cycle a TRACK attempt resolves: also dropped. A new attempt needs a start while IDLE.
- Counters:
  - pass_cnt and fail_cnt increment with their pulses and hold at 2^STAT_W-1.
  - pass and fail are never high together.

Decomposition:
- Package throughout_chk_pkg holds:
  - fail_cause_e (NONE, QUAL, TIMEOUT);
  - state_e (IDLE, TRACK);
  - the function lowest_zero_idx used for offend_idx.
- One sub-module, sat_counter (parameter W, inputs inc and rst_n), instantiated twice for the pass and fail counters.

Test Plan:
- NUM_EV=2, win_len=4: start with qual=1, ev=00; ev[0]=1 at cycle 1; ev[1]=1 at cycle 3; qual held 1 -> pass=1 one cycle after cycle 3, latency=3, pass_cnt=1.
- Same setup, but qual drops to 0 at cycle 3, the cycle ev[1] rises -> fail=1, fail_cause=1 (QUAL), no pass.
- NUM_EV=4, win_len=2: ev=0101 throughout, qual=1 -> fail at cycle 2 with fail_cause=2 (TIMEOUT), offend_idx=1.
- start with qual=1 and ev all ones at cycle 0 -> pass with latency=0, busy never rises. Also start with qual=0 -> immediate fail QUAL.
- Second start at cycle 2 of an active attempt -> start_drop=1, the first attempt resolves normally, and the counters change by exactly 1.
- rst_n asserted at cycle 2 of an attempt -> all outputs 0 immediately, no pass or fail. Also force 70000 passes -> pass_cnt=65535.

Source files
------------

// File: rtl/throughout_and_checker_pkg.sv
// Shared types and helpers for the throughout/and checker.
//   fail_cause_e    : reason reported with a fail pulse
//   state_e         : checker FSM states
//   lowest_zero_idx : index of the lowest clear bit among the first n bits
package throughout_chk_pkg;

    // Widest supported event vector; the helper works on this width.
    localparam int unsigned MAX_CH = 16;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        QUAL    = 2'd1,
        TIMEOUT = 2'd2
    } fail_cause_e;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Returns 0 when no bit below n is clear.
    function automatic logic [3:0] lowest_zero_idx(input logic [MAX_CH-1:0] v,
                                                   input int unsigned n);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < n && !found && !v[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/throughout_and_checker_if.sv
// Bus between a protocol block (master: drives the attempt inputs) and the
// checker (slave: returns status, pulses and counters).
//   start/qual/ev/win_len : attempt inputs
//   busy/pass/fail/...    : registered checker status and saturating counters
interface throughout_chk_if #(
    parameter int unsigned NUM_EV  = 2,
    parameter int unsigned MAX_WIN = 15,
    parameter int unsigned STAT_W  = 16
);
    localparam int unsigned CNT_W = $clog2(MAX_WIN + 1);
    localparam int unsigned IDX_W = $clog2(NUM_EV);

    logic              start;
    logic              qual;
    logic [NUM_EV-1:0] ev;
    logic [CNT_W-1:0]  win_len;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_cause;
    logic [IDX_W-1:0]  offend_idx;
    logic [CNT_W-1:0]  latency;
    logic              start_drop;
    logic [STAT_W-1:0] pass_cnt;
    logic [STAT_W-1:0] fail_cnt;

    modport master (
        output start, qual, ev, win_len,
        input  busy, pass, fail, fail_cause, offend_idx, latency, start_drop,
        input  pass_cnt, fail_cnt
    );

    modport slave (
        input  start, qual, ev, win_len,
        output busy, pass, fail, fail_cause, offend_idx, latency, start_drop,
        output pass_cnt, fail_cnt
    );

endinterface

// File: rtl/throughout_and_checker_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count enable
//   cnt        : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && cnt_q != {W{1'b1}}) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/throughout_and_checker.sv
// On-chip monitor for "qual throughout (ev[0] and ... ev[NUM_EV-1])" with
// first-match resolution, a programmable window and failure-cause reporting.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of throughout_chk_if (attempt inputs in, registered
//                busy/pass/fail/cause/offend_idx/latency/start_drop and
//                saturating pass/fail counters out)
module throughout_and_checker
    import throughout_chk_pkg::*;
#(
    parameter int unsigned NUM_EV  = 2,
    parameter int unsigned MAX_WIN = 15,
    parameter int unsigned STAT_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    throughout_chk_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WIN + 1);
    localparam int unsigned IDX_W = $clog2(NUM_EV);

    state_e            state_q, state_d;
    logic [NUM_EV-1:0] seen_q, seen_d;
    logic [CNT_W-1:0]  elapsed_q, elapsed_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    fail_cause_e       cause_q, cause_d;
    logic [IDX_W-1:0]  offend_q, offend_d;
    logic [CNT_W-1:0]  latency_q, latency_d;
    logic              drop_q, drop_d;

    logic [NUM_EV-1:0] merged;
    logic [CNT_W-1:0]  elapsed_inc;

    // Channels are sticky: once seen they stay seen for the attempt.
    assign merged      = seen_q | bus.ev;
    assign elapsed_inc = elapsed_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        elapsed_d = elapsed_q;
        win_d     = win_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        cause_d   = NONE;
        offend_d  = '0;
        latency_d = '0;
        drop_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    win_d     = bus.win_len;
                    elapsed_d = '0;
                    if (!bus.qual) begin
                        fail_d  = 1'b1;
                        cause_d = QUAL;
                    end else if (&bus.ev) begin
                        pass_d = 1'b1;
                    end else if (bus.win_len == '0) begin
                        fail_d   = 1'b1;
                        cause_d  = TIMEOUT;
                        offend_d = IDX_W'(lowest_zero_idx(MAX_CH'(bus.ev), NUM_EV));
                    end else begin
                        seen_d  = bus.ev;
                        state_d = TRACK;
                    end
                end
            end
            TRACK: begin
                // No overlapping attempts, even on the resolving cycle.
                drop_d = bus.start;
                // qual outranks a same-cycle match: throughout covers the end point.
                if (!bus.qual) begin
                    fail_d  = 1'b1;
                    cause_d = QUAL;
                    state_d = IDLE;
                end else if (&merged) begin
                    pass_d    = 1'b1;
                    latency_d = elapsed_inc;
                    state_d   = IDLE;
                end else if (elapsed_inc == win_q) begin
                    fail_d   = 1'b1;
                    cause_d  = TIMEOUT;
                    offend_d = IDX_W'(lowest_zero_idx(MAX_CH'(merged), NUM_EV));
                    state_d  = IDLE;
                end else begin
                    seen_d    = merged;
                    elapsed_d = elapsed_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            elapsed_q <= '0;
            win_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            cause_q   <= NONE;
            offend_q  <= '0;
            latency_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            elapsed_q <= elapsed_d;
            win_q     <= win_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            cause_q   <= cause_d;
            offend_q  <= offend_d;
            latency_q <= latency_d;
            drop_q    <= drop_d;
        end
    end

    // Counters step on the same edge that raises the pulse.
    sat_counter #(.W(STAT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pass_d),
        .cnt   (bus.pass_cnt)
    );

    sat_counter #(.W(STAT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_d),
        .cnt   (bus.fail_cnt)
    );

    assign bus.busy       = (state_q == TRACK);
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.fail_cause = cause_q;
    assign bus.offend_idx = offend_q;
    assign bus.latency    = latency_q;
    assign bus.start_drop = drop_q;

endmodule

// File: tb/tb_throughout_and_checker.sv
// Bench for throughout_and_checker: directed scenarios with literal
// expectations, random traffic against an attempt-history model, and
// counter saturation.
module tb_throughout_and_checker;

    localparam int unsigned NUM_EV  = 4;
    localparam int unsigned MAX_WIN = 15;
    localparam int unsigned STAT_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int          SAT_MAX = (1 << STAT_W) - 1;

    logic clk;
    logic rst_n;

    throughout_chk_if #(.NUM_EV(NUM_EV), .MAX_WIN(MAX_WIN), .STAT_W(STAT_W)) bus ();

    throughout_and_checker #(.NUM_EV(NUM_EV), .MAX_WIN(MAX_WIN), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // An open attempt is the list of ev samples since its start cycle.
    logic [NUM_EV-1:0] hist[$];
    int att_win;
    int e_busy, e_pass, e_fail, e_cause, e_off, e_lat, e_drop, e_pcnt, e_fcnt;

    function automatic int first_unseen(input logic [NUM_EV-1:0] m);
        for (int i = 0; i < int'(NUM_EV); i++) begin
            if (!m[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            att_win <= 0;
            e_busy <= 0; e_pass <= 0; e_fail <= 0; e_cause <= 0; e_off <= 0;
            e_lat  <= 0; e_drop <= 0; e_pcnt <= 0; e_fcnt  <= 0;
        end else begin
            automatic int p = 0, f = 0, cause = 0, off = 0, lat = 0, drop = 0;
            automatic logic [NUM_EV-1:0] seen = bus.ev;
            if (hist.size() == 0) begin
                if (bus.start) begin
                    if (!bus.qual) begin
                        f = 1; cause = 1;
                    end else if (&bus.ev) begin
                        p = 1; lat = 0;
                    end else if (bus.win_len == 0) begin
                        f = 1; cause = 2; off = first_unseen(bus.ev);
                    end else begin
                        hist.push_back(bus.ev);
                        att_win <= int'(bus.win_len);
                    end
                end
            end else begin
                automatic int k = hist.size();
                foreach (hist[i]) seen = seen | hist[i];
                drop = int'(bus.start);
                if (!bus.qual) begin
                    f = 1; cause = 1; hist.delete();
                end else if (&seen) begin
                    p = 1; lat = k; hist.delete();
                end else if (k == att_win) begin
                    f = 1; cause = 2; off = first_unseen(seen); hist.delete();
                end else begin
                    hist.push_back(bus.ev);
                end
            end
            e_busy  <= (hist.size() != 0) ? 1 : 0;
            e_pass  <= p;
            e_fail  <= f;
            e_cause <= cause;
            e_off   <= off;
            e_lat   <= lat;
            e_drop  <= drop;
            e_pcnt  <= (p != 0 && e_pcnt < SAT_MAX) ? e_pcnt + 1 : e_pcnt;
            e_fcnt  <= (f != 0 && e_fcnt < SAT_MAX) ? e_fcnt + 1 : e_fcnt;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("busy",       32'(bus.busy),       e_busy);
        chk("pass",       32'(bus.pass),       e_pass);
        chk("fail",       32'(bus.fail),       e_fail);
        chk("fail_cause", 32'(bus.fail_cause), e_cause);
        chk("offend_idx", 32'(bus.offend_idx), e_off);
        chk("latency",    32'(bus.latency),    e_lat);
        chk("start_drop", 32'(bus.start_drop), e_drop);
        chk("pass_cnt",   32'(bus.pass_cnt),   e_pcnt);
        chk("fail_cnt",   32'(bus.fail_cnt),   e_fcnt);
        chk("pass_fail_excl", 32'(bus.pass & bus.fail), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     32'(bus.busy),       0);
        chk({tag, "_pass"},     32'(bus.pass),       0);
        chk({tag, "_fail"},     32'(bus.fail),       0);
        chk({tag, "_cause"},    32'(bus.fail_cause), 0);
        chk({tag, "_drop"},     32'(bus.start_drop), 0);
        chk({tag, "_pass_cnt"}, 32'(bus.pass_cnt),   0);
        chk({tag, "_fail_cnt"}, 32'(bus.fail_cnt),   0);
    endtask

    // Drive one cycle of inputs, clock it, then compare on the falling edge.
    task automatic step(input logic s, input logic q, input logic [NUM_EV-1:0] e,
                        input logic [CNT_W-1:0] w);
        bus.start   = s;
        bus.qual    = q;
        bus.ev      = e;
        bus.win_len = w;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.qual    = 1'b0;
        bus.ev      = '0;
        bus.win_len = '0;
        #7;
        chk_all_zero("reset");
        #5 rst_n = 1'b1;
        @(negedge clk);

        // Two live channels (ev[3:2] held high), window 4: match at cycle 3.
        step(1'b1, 1'b1, 4'b1100, 4'd4);
        chk("t1_busy", 32'(bus.busy), 1);
        step(1'b0, 1'b1, 4'b1101, 4'd0);
        step(1'b0, 1'b1, 4'b1100, 4'd0);
        step(1'b0, 1'b1, 4'b1110, 4'd0);
        chk("t1_pass", 32'(bus.pass), 1);
        chk("t1_latency", 32'(bus.latency), 3);
        chk("t1_pass_cnt", 32'(bus.pass_cnt), 1);

        // qual drops on the completing cycle: QUAL wins.
        step(1'b1, 1'b1, 4'b1100, 4'd4);
        step(1'b0, 1'b1, 4'b1101, 4'd0);
        step(1'b0, 1'b1, 4'b1100, 4'd0);
        step(1'b0, 1'b0, 4'b1110, 4'd0);
        chk("t2_fail", 32'(bus.fail), 1);
        chk("t2_cause", 32'(bus.fail_cause), 1);
        chk("t2_pass", 32'(bus.pass), 0);

        // Window 2 with ev=0101 held: timeout, channel 1 offends.
        step(1'b1, 1'b1, 4'b0101, 4'd2);
        step(1'b0, 1'b1, 4'b0101, 4'd0);
        chk("t3_no_early_fail", 32'(bus.fail), 0);
        step(1'b0, 1'b1, 4'b0101, 4'd0);
        chk("t3_fail", 32'(bus.fail), 1);
        chk("t3_cause", 32'(bus.fail_cause), 2);
        chk("t3_offend", 32'(bus.offend_idx), 1);

        // Start-cycle resolution.
        step(1'b1, 1'b1, 4'b1111, 4'd5);
        chk("t4_pass", 32'(bus.pass), 1);
        chk("t4_latency", 32'(bus.latency), 0);
        chk("t4_busy", 32'(bus.busy), 0);
        step(1'b1, 1'b0, 4'b1111, 4'd5);
        chk("t4_qual_fail", 32'(bus.fail), 1);
        chk("t4_qual_cause", 32'(bus.fail_cause), 1);

        // Overlapping start is dropped; first attempt still resolves.
        step(1'b1, 1'b1, 4'b1100, 4'd4);
        step(1'b0, 1'b1, 4'b1101, 4'd0);
        step(1'b1, 1'b1, 4'b1100, 4'd0);
        chk("t5_drop", 32'(bus.start_drop), 1);
        step(1'b0, 1'b1, 4'b1110, 4'd0);
        chk("t5_pass", 32'(bus.pass), 1);
        chk("t5_pass_cnt", 32'(bus.pass_cnt), 3);
        chk("t5_fail_cnt", 32'(bus.fail_cnt), 3);

        // Asynchronous reset mid-attempt.
        step(1'b1, 1'b1, 4'b1100, 4'd4);
        step(1'b0, 1'b1, 4'b1100, 4'd0);
        step(1'b0, 1'b1, 4'b1100, 4'd0);
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0, ($urandom % 16) != 0,
                 NUM_EV'($urandom | $urandom), CNT_W'($urandom_range(0, MAX_WIN)));
        end

        // Counter saturation.
        for (int i = 0; i < 66000; i++) begin
            step(1'b1, 1'b1, 4'b1111, 4'd1);
        end
        chk("sat_pass_cnt", 32'(bus.pass_cnt), 65535);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
